// File: rtl/gt_rx_fifo_pkg.sv
// Shared defaults for the GT receive path.
package gt_rx_fifo_pkg;
  localparam int GT_FIFO_SIZE_DEF = 64;
endpackage

// File: rtl/gt_rx_fifo_mem.sv
// DEPTH x W simple dual-port array: synchronous write, asynchronous read.
// Has no reset, so it maps onto distributed RAM.
module gt_rx_fifo_mem #(
  parameter int W     = 64,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/gt_rx_fifo.sv
// FWFT elastic RX buffer (GT -> message_handler); push-to-out_valid latency 1 cycle; gt_ready = !full, never depends on out_ready.
// Optional occupancy statistics are enabled by defining GT_RX_FIFO_STATS_EN.
module gt_rx_fifo
  import gt_rx_fifo_pkg::*;
#(
  parameter int GT_FIFO_SIZE = GT_FIFO_SIZE_DEF,
  parameter int DEPTH        = 16,
  parameter int AFULL_THRESH = 12,
  parameter int AW           = $clog2(DEPTH),
  parameter int CW           = $clog2(DEPTH) + 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [GT_FIFO_SIZE-1:0] gt_data,
  input  logic                    gt_valid,
  output logic                    gt_ready,
  output logic [GT_FIFO_SIZE-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CW-1:0]           count,
  output logic                    almost_full,
  output logic                    overflow,
  output logic [31:0]             stat_pushes,
  output logic [CW-1:0]           stat_hiwater
);
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count_nxt;
  logic          push, pop;

  // Full/empty come from count only, so the pointers may wrap freely.
  assign gt_ready  = (count != CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = gt_valid && gt_ready;
  assign pop       = out_valid && out_ready;
  assign count_nxt = count + CW'(push) - CW'(pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      almost_full <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count       <= count_nxt;
      almost_full <= (count_nxt >= CW'(AFULL_THRESH));
      if (gt_valid && !gt_ready) overflow <= 1'b1;
    end
  end

  gt_rx_fifo_mem #(
    .W     (GT_FIFO_SIZE),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (gt_data),
    .raddr (rd_ptr),
    .rdata (out_data)
  );

`ifdef GT_RX_FIFO_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_pushes  <= '0;
      stat_hiwater <= '0;
    end else begin
      if (push && stat_pushes != 32'hFFFF_FFFF) stat_pushes <= stat_pushes + 32'd1;
      if (count_nxt > stat_hiwater) stat_hiwater <= count_nxt;
    end
  end
`else
  assign stat_pushes  = '0;
  assign stat_hiwater = '0;
`endif
endmodule

// File: tb/tb_gt_rx_fifo.sv
// Directed self-checking bench for gt_rx_fifo (DEPTH=16, AFULL_THRESH=12).
module tb_gt_rx_fifo;
  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] gt_data;
  logic        gt_valid;
  logic        gt_ready;
  logic [63:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  count;
  logic        almost_full;
  logic        overflow;
  logic [31:0] stat_pushes;
  logic [4:0]  stat_hiwater;

  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] q[$];

  always #5 clk = ~clk;

  gt_rx_fifo #(.GT_FIFO_SIZE(64), .DEPTH(16), .AFULL_THRESH(12)) dut (
    .clk          (clk),
    .reset        (reset),
    .gt_data      (gt_data),
    .gt_valid     (gt_valid),
    .gt_ready     (gt_ready),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .count        (count),
    .almost_full  (almost_full),
    .overflow     (overflow),
    .stat_pushes  (stat_pushes),
    .stat_hiwater (stat_hiwater)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [63:0] d);
    gt_valid = 1'b1;
    gt_data  = d;
    tick();
    gt_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b1; gt_valid = 1'b0; out_ready = 1'b0; gt_data = '0;
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_gt_ready", gt_ready, 1);
    chk("rst_count", count, 0);
    chk("rst_afull", almost_full, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_stat_pushes", stat_pushes, 0);
    reset = 1'b0;
    tick();

    // Burst of 5 with consumer stalled, then drain.
    for (int i = 1; i <= 5; i++) push_word(64'(i));
    chk("burst_count", count, 5);
    chk("burst_valid", out_valid, 1);
    chk("burst_head", out_data, 64'h1);
    out_ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      chk("drain_valid", out_valid, 1);
      chk("drain_data", out_data, 64'(i));
      tick();
    end
    out_ready = 1'b0;
    chk("drain_empty", out_valid, 0);
    chk("drain_count", count, 0);

    // Fill to 16, watch almost_full threshold.
    gt_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      gt_data = 64'(100 + i);
      tick();
      if (i == 10) chk("afull_at_11", almost_full, 0);
      if (i == 11) chk("afull_at_12", almost_full, 1);
    end
    chk("full_gt_ready", gt_ready, 0);
    chk("full_count", count, 16);
    chk("full_no_ovf_yet", overflow, 0);
    gt_data = 64'd999;
    tick();
    gt_valid = 1'b0;
    chk("ovf_set", overflow, 1);
    chk("ovf_count", count, 16);

    // Full with simultaneous pop: pop only, push refused.
    gt_valid = 1'b1; gt_data = 64'd777; out_ready = 1'b1;
    chk("fullpop_head", out_data, 100);
    tick();
    gt_valid = 1'b0; out_ready = 1'b0;
    chk("fullpop_count", count, 15);
    chk("fullpop_gt_ready", gt_ready, 1);
    chk("fullpop_head2", out_data, 101);
    chk("ovf_sticky", overflow, 1);

    // Drain down to 3, then stream across pointer wrap.
    out_ready = 1'b1;
    repeat (12) tick();
    out_ready = 1'b0;
    chk("pre_stream_count", count, 3);
    q = {64'd113, 64'd114, 64'd115};
    gt_valid = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 100; k++) begin
      gt_data = 64'(200 + k);
      chk("stream_data", out_data, q.pop_front());
      q.push_back(64'(200 + k));
      tick();
      if (k % 25 == 24) chk("stream_count", count, 3);
    end
    gt_valid = 1'b0; out_ready = 1'b0;

    // Grow to 7, then async reset mid-cycle.
    for (int i = 0; i < 4; i++) push_word(64'(500 + i));
    chk("pre_rst_count", count, 7);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_count", count, 0);
    chk("arst_overflow", overflow, 0);
    chk("arst_gt_ready", gt_ready, 1);
    chk("arst_afull", almost_full, 0);
    #2;
    reset = 1'b0;
    tick();
    push_word(64'hABC);
    chk("post_rst_valid", out_valid, 1);
    chk("post_rst_data", out_data, 64'hABC);
    chk("post_rst_count", count, 1);

    // Stats: 9 pushes to peak, then 11 push+pop cycles.
    pulse_reset();
    for (int i = 0; i < 9; i++) push_word(64'(i));
    gt_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      gt_data = 64'(50 + i);
      tick();
    end
    gt_valid = 1'b0;
    chk("stats_count", count, 9);
    repeat (9) tick();
    out_ready = 1'b0;
`ifdef GT_RX_FIFO_STATS_EN
    chk("stat_pushes", stat_pushes, 20);
    chk("stat_hiwater", stat_hiwater, 9);
`else
    chk("stat_pushes", stat_pushes, 0);
    chk("stat_hiwater", stat_hiwater, 0);
`endif
    chk("final_empty", out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
